// File: rtl/mem_mmio_if.sv
// Single memory-port bus between the core's control FSM (master) and the
// memory/MMIO responder (slave).
interface mem_mmio_if;
   logic [31:0] addr;
   logic [31:0] wd;
   logic        we;
   logic [2:0]  size;
   logic [31:0] rd;
   logic        misaligned;

   modport master (
      output addr, wd, we, size,
      input  rd, misaligned
   );

   modport slave (
      input  addr, wd, we, size,
      output rd, misaligned
   );
endinterface

// File: rtl/mem_mmio.sv
// Memory-side responder: byte-laned word RAM plus a small MMIO block
// (GPIO, timer with compare, sticky fault capture). Zero-latency reads.
module mem_mmio #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rstn,
   mem_mmio_if.slave   bus,
   output logic [31:0] gpio_out,
   output logic        timer_hit
);
   localparam int          AW        = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
   localparam logic [31:0] RAM_BYTES = 32'(4 * MEM_WORDS);

   logic [31:0]   mmio_off;
   logic [2:0]    reg_sel;
   logic          is_ram;
   logic          is_mmio;
   logic          misaligned;
   logic          fault;
   logic          wr_ok;
   logic          mmio_wr;
   logic [AW-1:0] widx;
   logic [3:0]    lane_be;
   logic [3:0]    ram_be;
   logic [31:0]   lane_data;
   logic [31:0]   ram_word;
   logic [31:0]   mmio_word;
   logic [31:0]   fetch_word;
   logic [7:0]    byte_sel;
   logic [15:0]   half_sel;
   logic [31:0]   rd_val;

   logic [31:0] gpio_q, gpio_d;
   logic [31:0] mtime_q, mtime_d;
   logic [31:0] mtimecmp_q, mtimecmp_d;
   logic [1:0]  status_q, status_d;
   logic [31:0] fault_addr_q, fault_addr_d;

   // Subtraction wraps for addresses below the base, so one compare covers both bounds.
   assign mmio_off = bus.addr - MMIO_BASE;
   assign reg_sel  = mmio_off[4:2];
   assign is_ram   = bus.addr < RAM_BYTES;
   assign is_mmio  = mmio_off < 32'd32;
   assign widx     = bus.addr[AW+1:2];

   always_comb begin
      misaligned = 1'b1;
      case (bus.size)
         3'b000, 3'b100: misaligned = 1'b0;
         3'b001, 3'b101: misaligned = bus.addr[0];
         3'b010:         misaligned = |bus.addr[1:0];
         default:        misaligned = 1'b1;
      endcase
   end

   assign fault   = bus.we & (misaligned | ~(is_ram | is_mmio) | (is_mmio & (bus.size != 3'b010)));
   assign wr_ok   = bus.we & ~fault;
   assign mmio_wr = wr_ok & is_mmio;

   always_comb begin
      lane_be   = 4'b1111;
      lane_data = bus.wd;
      case (bus.size[1:0])
         2'b00: begin
            lane_be   = 4'b0001 << bus.addr[1:0];
            lane_data = {4{bus.wd[7:0]}};
         end
         2'b01: begin
            lane_be   = bus.addr[1] ? 4'b1100 : 4'b0011;
            lane_data = {2{bus.wd[15:0]}};
         end
         default: begin
            lane_be   = 4'b1111;
            lane_data = bus.wd;
         end
      endcase
   end

   assign ram_be = (wr_ok & is_ram) ? lane_be : 4'b0000;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_lane
         logic [7:0] mem_q [MEM_WORDS];
         always_ff @(posedge clk) begin
            if (ram_be[gi]) begin
               mem_q[widx] <= lane_data[8*gi +: 8];
            end
         end
         assign ram_word[8*gi +: 8] = mem_q[widx];
      end
   endgenerate

   always_comb begin
      mmio_word = 32'd0;
      case (reg_sel)
         3'd0:    mmio_word = gpio_q;
         3'd1:    mmio_word = mtime_q;
         3'd2:    mmio_word = mtimecmp_q;
         3'd3:    mmio_word = {30'd0, status_q};
         3'd4:    mmio_word = fault_addr_q;
         default: mmio_word = 32'd0;
      endcase
   end

   assign fetch_word = is_ram ? ram_word : mmio_word;

   always_comb begin
      byte_sel = fetch_word[7:0];
      case (bus.addr[1:0])
         2'd0: byte_sel = fetch_word[7:0];
         2'd1: byte_sel = fetch_word[15:8];
         2'd2: byte_sel = fetch_word[23:16];
         2'd3: byte_sel = fetch_word[31:24];
         default: byte_sel = fetch_word[7:0];
      endcase
      half_sel = bus.addr[1] ? fetch_word[31:16] : fetch_word[15:0];
   end

   always_comb begin
      rd_val = 32'd0;
      case (bus.size)
         3'b000:  rd_val = {{24{byte_sel[7]}}, byte_sel};
         3'b100:  rd_val = {24'd0, byte_sel};
         3'b001:  rd_val = {{16{half_sel[15]}}, half_sel};
         3'b101:  rd_val = {16'd0, half_sel};
         3'b010:  rd_val = fetch_word;
         default: rd_val = 32'd0;
      endcase
      if (misaligned || !(is_ram || is_mmio)) begin
         rd_val = 32'd0;
      end
   end

   assign bus.rd         = rd_val;
   assign bus.misaligned = misaligned;

   always_comb begin
      gpio_d       = gpio_q;
      mtime_d      = mtime_q + 32'd1;
      mtimecmp_d   = mtimecmp_q;
      status_d     = status_q;
      fault_addr_d = fault_addr_q;
      if (mmio_wr) begin
         case (reg_sel)
            3'd0:    gpio_d     = bus.wd;
            3'd1:    mtime_d    = bus.wd;
            3'd2:    mtimecmp_d = bus.wd;
            3'd3:    status_d   = status_q & ~bus.wd[1:0];
            default: ;
         endcase
      end
      // Sets are applied after W1C so a coincident set wins.
      if (mtime_q == mtimecmp_q) begin
         status_d[0] = 1'b1;
      end
      if (fault) begin
         status_d[1]  = 1'b1;
         fault_addr_d = bus.addr;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         gpio_q       <= 32'd0;
         mtime_q      <= 32'd0;
         mtimecmp_q   <= 32'hFFFF_FFFF;
         status_q     <= 2'b00;
         fault_addr_q <= 32'd0;
      end else begin
         gpio_q       <= gpio_d;
         mtime_q      <= mtime_d;
         mtimecmp_q   <= mtimecmp_d;
         status_q     <= status_d;
         fault_addr_q <= fault_addr_d;
      end
   end

   assign gpio_out  = gpio_q;
   assign timer_hit = status_q[0];
endmodule

// File: tb/tb_mem_mmio.sv
// Directed bench for mem_mmio: RAM lanes/extension, faults, MMIO timer,
// wrap and asynchronous reset, with immediate-assertion checks.
module tb_mem_mmio;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam logic [31:0] GPIO = BASE + 32'h00;
   localparam logic [31:0] MTIM = BASE + 32'h04;
   localparam logic [31:0] MCMP = BASE + 32'h08;
   localparam logic [31:0] STAT = BASE + 32'h0C;
   localparam logic [31:0] FADR = BASE + 32'h10;
   localparam logic [2:0]  SB = 3'b000, SH = 3'b001, SW = 3'b010, BU = 3'b100, HU = 3'b101;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [31:0] gpio_out;
   logic        timer_hit;
   int          errors = 0;
   int          checks = 0;

   mem_mmio_if bus_if ();

   mem_mmio #(.MEM_WORDS(1024), .MMIO_BASE(BASE)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .bus       (bus_if.slave),
      .gpio_out  (gpio_out),
      .timer_hit (timer_hit)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
      @(negedge clk);
      bus_if.addr = a;
      bus_if.wd   = d;
      bus_if.size = s;
      bus_if.we   = 1'b1;
      @(posedge clk);
      #1;
      bus_if.we   = 1'b0;
      $display("store addr=%h wd=%h size=%b", a, d, s);
   endtask

   task automatic load(input string tag, input logic [31:0] a, input logic [2:0] s, input logic [31:0] exp);
      bus_if.we   = 1'b0;
      bus_if.addr = a;
      bus_if.size = s;
      #1;
      $display("load  addr=%h size=%b rd=%h", a, s, bus_if.rd);
      chk(tag, bus_if.rd, exp);
   endtask

   initial begin
      bus_if.addr = 32'd0;
      bus_if.wd   = 32'd0;
      bus_if.we   = 1'b0;
      bus_if.size = SW;

      // Reset values, sampled while still held in reset
      #12;
      chk("rst_gpio_out", gpio_out, 32'd0);
      chk("rst_timer_hit", {31'd0, timer_hit}, 32'd0);
      load("rst_status", STAT, SW, 32'd0);
      load("rst_mtimecmp", MCMP, SW, 32'hFFFF_FFFF);
      load("rst_mtime", MTIM, SW, 32'd0);
      @(negedge clk);
      rstn = 1'b1;

      // Byte/half stores and extension
      store(32'h10, 32'h1122_3344, SW);
      store(32'h11, 32'h0000_00AA, SB);
      store(32'h12, 32'h0000_BEEF, SH);
      load("lw_10", 32'h10, SW, 32'hBEEF_AA44);
      load("lb_11", 32'h11, SB, 32'hFFFF_FFAA);
      load("lbu_11", 32'h11, BU, 32'h0000_00AA);
      load("lh_12", 32'h12, SH, 32'hFFFF_BEEF);
      load("lhu_12", 32'h12, HU, 32'h0000_BEEF);
      load("lb_10", 32'h10, SB, 32'h0000_0044);
      load("lh_misal", 32'h11, SH, 32'd0);

      // Misaligned store
      store(32'h20, 32'h5566_7788, SW);
      bus_if.addr = 32'h22;
      bus_if.size = SW;
      #1;
      chk("misaligned_flag", {31'd0, bus_if.misaligned}, 32'd1);
      store(32'h22, 32'hDEAD_BEEF, SW);
      load("misal_ram", 32'h20, SW, 32'h5566_7788);
      load("misal_status", STAT, SW, 32'h2);
      load("misal_faddr", FADR, SW, 32'h22);
      store(STAT, 32'h2, SW);
      load("status_w1c", STAT, SW, 32'h0);

      // Sub-word MMIO and unmapped accesses
      store(GPIO, 32'h0000_00FF, SB);
      chk("subword_gpio", gpio_out, 32'd0);
      load("subword_status", STAT, SW, 32'h2);
      load("subword_faddr", FADR, SW, GPIO);
      store(STAT, 32'h2, SW);
      load("unmapped_rd", 32'h4000_0000, SW, 32'd0);
      @(posedge clk);
      #1;
      load("unmapped_nofault", STAT, SW, 32'h0);
      store(FADR, 32'h1234_5678, SW);
      load("faddr_ro", FADR, SW, GPIO);
      store(GPIO, 32'h0000_00A5, SW);
      chk("gpio_write", gpio_out, 32'h0000_00A5);
      load("gpio_read", GPIO, SW, 32'h0000_00A5);

      // Timer: hit 11 cycles after MTIME write
      store(MCMP, 32'd20, SW);
      store(MTIM, 32'd10, SW);
      load("mtime_n1", MTIM, SW, 32'd10);
      @(posedge clk);
      #1;
      load("mtime_n2", MTIM, SW, 32'd11);
      repeat (9) @(posedge clk);
      #1;
      chk("hit_n10", {31'd0, timer_hit}, 32'd0);
      @(posedge clk);
      #1;
      chk("hit_n11", {31'd0, timer_hit}, 32'd1);
      store(STAT, 32'h1, SW);
      chk("hit_cleared", {31'd0, timer_hit}, 32'd0);

      // W1C on the same edge as a hit: set wins
      store(MTIM, 32'd19, SW);
      @(posedge clk);
      store(STAT, 32'h1, SW);
      chk("set_wins", {31'd0, timer_hit}, 32'd1);
      store(STAT, 32'h1, SW);
      load("status_after_w1c", STAT, SW, 32'h0);

      // Wrap
      store(MCMP, 32'hFFFF_FFFF, SW);
      store(MTIM, 32'hFFFF_FFFF, SW);
      load("wrap_n1", MTIM, SW, 32'hFFFF_FFFF);
      chk("wrap_nohit", {31'd0, timer_hit}, 32'd0);
      @(posedge clk);
      #1;
      load("wrap_n2", MTIM, SW, 32'd0);
      chk("wrap_hit", {31'd0, timer_hit}, 32'd1);

      // Async reset mid-run, with GPIO=A5 and STATUS=3
      store(GPIO, 32'h1, SB);
      load("pre_rst_status", STAT, SW, 32'h3);
      @(posedge clk);
      #2;
      rstn = 1'b0;
      #1;
      chk("arst_gpio_out", gpio_out, 32'd0);
      chk("arst_timer_hit", {31'd0, timer_hit}, 32'd0);
      load("arst_status", STAT, SW, 32'd0);
      load("arst_faddr", FADR, SW, 32'd0);
      load("arst_mtimecmp", MCMP, SW, 32'hFFFF_FFFF);
      load("arst_mtime", MTIM, SW, 32'd0);
      load("ram_not_reset", 32'h10, SW, 32'hBEEF_AA44);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_mmio.md
# mem_mmio

Memory-side responder for the multicycle core's single memory port. Serves instruction fetches, loads and stores issued by the control FSM. Decodes `addr` into a word RAM or a small MMIO register file (GPIO, free-running timer with compare, sticky fault capture). Performs byte-lane extraction, sign/zero extension and byte-lane write masking according to the funct3 load/store size code.

## Interface
Parameters:
- `MEM_WORDS`, 1024: RAM depth in 32-bit words; RAM spans bytes 0 .. 4*MEM_WORDS-1.
- `MMIO_BASE`, 32'h8000_0000: base of the 32-byte MMIO window.

Ports:
- `clk` in 1: clock.
- `rstn` in 1: reset, asynchronous, active-low.
- `addr` in 32: byte address, driven every cycle.
- `wd` in 32: store data; the low bytes hold the value for B/H.
- `we` in 1: store strobe, sampled at the rising edge.
- `size` in 3: funct3 code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `rd` out 32: load data, combinational, extended per `size`.
- `misaligned` out 1: combinational alignment flag for the current `addr`/`size`.
- `gpio_out` out 32: GPIO register.
- `timer_hit` out 1: copy of STATUS bit0.

## Operation
- Alignment: H/HU requires addr[0]=0; W requires addr[1:0]=0; B/BU is always aligned. Codes 011/110/111 count as misaligned.
- Region decode:
  - RAM: addr < 4*MEM_WORDS.
  - MMIO: MMIO_BASE <= addr < MMIO_BASE+32.
  - Anything else is unmapped.
- Reads (combinational, no enable):
  - Fetch word = RAM[addr[31:2]] or the addressed MMIO register.
  - B/BU selects byte addr[1:0]; H/HU selects half addr[1].
  - B and H sign-extend; BU and HU zero-extend.
  - `rd`=0 when the address is unmapped or misaligned.
- Writes at `posedge clk` when `we`=1:
  - RAM: updates only the addressed byte lanes. B writes wd[7:0] to lane addr[1:0]. H writes wd[15:0] to lanes {addr[1],0} and {addr[1],1}. W writes all lanes.
  - MMIO: accepts only W. A sub-word MMIO write is a fault and is ignored.
  - Fault = we & (misaligned | unmapped | sub-word MMIO). A fault suppresses the write, sets STATUS bit1 and loads FAULT_ADDR=addr.
  - Reads never raise faults, because the core drives garbage addresses in non-memory states.
- MMIO map (offsets from MMIO_BASE):
  - 0x00 GPIO, RW.
  - 0x04 MTIME, RW: +1 per cycle, wraps FFFF_FFFF -> 0. A write loads `wd` and skips that cycle's increment.
  - 0x08 MTIMECMP, RW.
  - 0x0C STATUS: bit0 timer hit, bit1 fault; both write-1-to-clear, other bits read 0.
  - 0x10 FAULT_ADDR, RO; writes are ignored without a fault.
  - 0x14-0x1C read 0, writes ignored.
- Timer: when MTIME==MTIMECMP (pre-increment value), STATUS bit0 is set at that edge. The bit stays sticky until cleared.
- Simultaneous set and W1C on the same STATUS bit in one edge: set wins.
- A faulting write to STATUS does not clear bits; it only sets bit1.

## Timing
- Reset (async, rstn=0):
  - GPIO=0, MTIME=0, MTIMECMP=FFFF_FFFF, STATUS=0, FAULT_ADDR=0.
  - Hence `gpio_out`=0 and `timer_hit`=0.
  - RAM contents are not reset.
  - Reset asserted mid-store: the store may or may not land; registers still take their reset values.
- Read latency is 0 cycles: `rd` is valid in the same cycle as `addr`/`size`. This matches the core latching instr/data at the end of FETCH/MEM_LOAD.
- Write latency is 1 edge: data is visible on `rd` the cycle after the `we` edge.
- An MTIME read returns the current register value. A store to MTIME at edge N reads back `wd` at cycle N+1 and `wd`+1 at N+2.
- STATUS/FAULT_ADDR update at the same edge as the faulting `we`.
- Timer-hit edge: STATUS bit0 is set at the edge where pre-increment MTIME==MTIMECMP, so `timer_hit`=1 from the following cycle.
- There are no multi-cycle transactions and no handshake. Every store completes in its strobe cycle.

## Test plan
- Byte/half stores and extension: SW 0x1122_3344 @0x10; SB 0xAA @0x11; SH 0xBEEF @0x12.
  - LW @0x10 -> 0xBEEF_AA44.
  - LB @0x11 -> 0xFFFF_FFAA; LBU @0x11 -> 0x0000_00AA.
  - LH @0x12 -> 0xFFFF_BEEF; LHU @0x12 -> 0x0000_BEEF.
- Misaligned store: SW @0x22 (we=1).
  - `misaligned`=1, RAM word 0x20 unchanged.
  - STATUS=0x2, FAULT_ADDR=0x22.
  - Writing 0x2 to STATUS then -> STATUS=0.
- Unmapped and sub-word MMIO: SB @MMIO_BASE+0 -> GPIO unchanged, fault set; LW @0x4000_0000 -> `rd`=0 and no fault; SW 0xA5 @MMIO_BASE -> `gpio_out`=0xA5 next cycle.
- Timer: write MTIMECMP=20, MTIME=10 at edge N.
  - MTIME reads 10 at N+1 and 11 at N+2.
  - `timer_hit` rises 11 cycles after the MTIME write.
  - W1C bit0 in the same cycle MTIME==MTIMECMP -> bit stays 1.
- Wrap: write MTIME=FFFF_FFFF -> reads 0 two cycles later; MTIMECMP=FFFF_FFFF hit fires on that wrap.
- Async reset mid-run: pulse rstn low between edges with GPIO=0xA5 and STATUS=3 -> all registers and outputs read reset values immediately, with no clock edge.
